// File: rtl/gsm_resp_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gsm_resp_parser                                                 |
// | Brief    : Classifies GSM modem reply lines into result codes and keeps a  |
// |            response timeout. Optional macro GSM_RESP_RING_EN enables the   |
// |            unsolicited RING / +CMTI: classification.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module gsm_resp_parser #(
    parameter int          MAX_LEN     = 8,
    parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_int,
    input  logic       wait_start,
    output logic       resp_valid,
    output logic [2:0] resp_code,
    output logic       busy
);

    localparam logic [7:0] c_CR = 8'h0D;
    localparam logic [7:0] c_LF = 8'h0A;
    localparam logic [7:0] c_GT = 8'h3E;

    localparam logic [2:0] c_CODE_NONE    = 3'd0;
    localparam logic [2:0] c_CODE_OK      = 3'd1;
    localparam logic [2:0] c_CODE_ERROR   = 3'd2;
    localparam logic [2:0] c_CODE_PROMPT  = 3'd3;
    localparam logic [2:0] c_CODE_CMGS    = 3'd4;
    localparam logic [2:0] c_CODE_OTHER   = 3'd5;
    localparam logic [2:0] c_CODE_TIMEOUT = 3'd6;
`ifdef GSM_RESP_RING_EN
    localparam logic [2:0] c_CODE_RING    = 3'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_buf [MAX_LEN];
    logic [5:0]  r_len;
    logic [7:0]  r_skid;
    logic        r_skid_vld;
    logic [23:0] r_cnt;
    logic        r_busy;
    logic        r_resp_valid;
    logic [2:0]  r_resp_code;

    logic        w_byte_vld;
    logic [7:0]  w_byte;
    logic [47:0] w_head;
    logic [2:0]  w_line_code;
    logic        w_line_unsol;
    logic        w_eval;
    logic        w_prompt;
    logic        w_expire;

    // A byte held over from an EVAL cycle is consumed before the live input.
    assign w_byte_vld = (r_state != S_EVAL) && (r_skid_vld || rx_int);
    assign w_byte     = r_skid_vld ? r_skid : rx_byte;

    assign w_head   = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], r_buf[5]};
    assign w_eval   = (r_state == S_EVAL);
    assign w_prompt = w_byte_vld && (r_state == S_IDLE) && (w_byte == c_GT);
    assign w_expire = r_busy && (r_cnt == 24'd1);

    always_comb begin
        w_line_code  = c_CODE_OTHER;
        w_line_unsol = 1'b0;
        if ((r_len == 6'd2) && (w_head[47:32] == "OK")) begin
            w_line_code = c_CODE_OK;
        end else if ((r_len == 6'd5) && (w_head[47:8] == "ERROR")) begin
            w_line_code = c_CODE_ERROR;
        end else if ((r_len >= 6'd6) && (w_head == "+CMGS:")) begin
            w_line_code = c_CODE_CMGS;
`ifdef GSM_RESP_RING_EN
        end else if ((r_len == 6'd4) && (w_head[47:16] == "RING")) begin
            w_line_code  = c_CODE_RING;
            w_line_unsol = 1'b1;
        end else if ((r_len >= 6'd6) && (w_head == "+CMTI:")) begin
            w_line_code  = c_CODE_RING;
            w_line_unsol = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= 6'd0;
            r_skid       <= 8'h00;
            r_skid_vld   <= 1'b0;
            r_cnt        <= 24'd0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_code  <= c_CODE_NONE;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            r_resp_valid <= 1'b0;

            if (r_state == S_EVAL) begin
                if (rx_int) begin
                    r_skid     <= rx_byte;
                    r_skid_vld <= 1'b1;
                end
            end else if (r_skid_vld && rx_int) begin
                r_skid <= rx_byte;
            end else begin
                r_skid_vld <= 1'b0;
            end

            // A line or prompt result in this cycle suppresses a coincident expiry.
            if (w_expire && !w_eval && !w_prompt) begin
                r_resp_valid <= 1'b1;
                r_resp_code  <= c_CODE_TIMEOUT;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_byte_vld && (w_byte != c_CR) && (w_byte != c_LF)) begin
                        if (w_byte == c_GT) begin
                            r_resp_valid <= 1'b1;
                            r_resp_code  <= c_CODE_PROMPT;
                        end else begin
                            r_buf[0] <= w_byte;
                            r_len    <= 6'd1;
                            r_state  <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_byte_vld) begin
                        if (w_byte == c_LF) begin
                            r_state <= S_EVAL;
                        end else if (w_byte != c_CR) begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                if (r_len == 6'(i)) begin
                                    r_buf[i] <= w_byte;
                                end
                            end
                            if (r_len != 6'd63) begin
                                r_len <= r_len + 6'd1;
                            end
                        end
                    end
                end
                S_EVAL: begin
                    r_resp_valid <= 1'b1;
                    r_resp_code  <= w_line_code;
                    r_len        <= 6'd0;
                    r_state      <= S_IDLE;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        r_buf[i] <= 8'h00;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (wait_start) begin
                r_busy <= 1'b1;
                r_cnt  <= TIMEOUT_CYC;
            end else if (w_expire || w_prompt || (w_eval && !w_line_unsol)) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                r_cnt <= r_cnt - 24'd1;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_code  = r_resp_code;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gsm_resp_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gsm_resp_parser                                              |
// | Brief    : Randomised bench for gsm_resp_parser against a line/deadline    |
// |            reference model; honours GSM_RESP_RING_EN like the design.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gsm_resp_parser;

    localparam int c_T = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_int = 1'b0;
    logic       wait_start = 1'b0;
    logic       resp_valid;
    logic [2:0] resp_code;
    logic       busy;

    always #5 clk = ~clk;

    gsm_resp_parser #(
        .MAX_LEN     (8),
        .TIMEOUT_CYC (24'(c_T))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_int     (rx_int),
        .wait_start (wait_start),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: the current line as text, a pending result edge and an
    // absolute timeout deadline.
    byte        m_q[$];
    bit         m_busy     = 0;
    int         m_deadline = -1;
    logic [2:0] m_code     = 3'd0;
    int         m_eval_due = -1;
    logic [2:0] m_eval_code;
    bit         m_eval_unsol;
    bit         m_pend_v   = 0;
    byte        m_pend;
    bit         m_exp_valid = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit is_line(input byte q[$], input string s);
        if (q.size() != s.len()) return 0;
        for (int i = 0; i < s.len(); i++) if (q[i] != s[i]) return 0;
        return 1;
    endfunction

    function automatic bit has_prefix(input byte q[$], input string s);
        if (q.size() < s.len()) return 0;
        for (int i = 0; i < s.len(); i++) if (q[i] != s[i]) return 0;
        return 1;
    endfunction

    task automatic model_byte(input byte b, input int n, inout bit prompt);
        if (m_q.size() == 0) begin
            if (b == ">") prompt = 1;
            else if (b != 8'h0D && b != 8'h0A) m_q.push_back(b);
        end else if (b == 8'h0A) begin
            m_eval_due   = n + 1;
            m_eval_unsol = 0;
            if (is_line(m_q, "OK"))            m_eval_code = 3'd1;
            else if (is_line(m_q, "ERROR"))    m_eval_code = 3'd2;
            else if (has_prefix(m_q, "+CMGS:")) m_eval_code = 3'd4;
`ifdef GSM_RESP_RING_EN
            else if (is_line(m_q, "RING") || has_prefix(m_q, "+CMTI:")) begin
                m_eval_code  = 3'd7;
                m_eval_unsol = 1;
            end
`endif
            else m_eval_code = 3'd5;
            m_q.delete();
        end else if (b != 8'h0D) begin
            m_q.push_back(b);
        end
    endtask

    task automatic tick(input bit r, input byte b, input bit ws, input bit rs);
        bit         res;
        bit         clr;
        bit         prompt;
        bit         expire;
        logic [2:0] code;
        rx_int     = r;
        rx_byte    = b;
        wait_start = ws;
        rst        = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            m_q.delete();
            m_busy      = 0;
            m_code      = 3'd0;
            m_eval_due  = -1;
            m_pend_v    = 0;
            m_exp_valid = 0;
        end else begin
            res    = 0;
            clr    = 0;
            prompt = 0;
            code   = 3'd0;
            expire = m_busy && (cyc == m_deadline);
            if (m_eval_due == cyc) begin
                res  = 1;
                code = m_eval_code;
                clr  = !m_eval_unsol;
            end
            if (m_pend_v) begin
                model_byte(m_pend, cyc, prompt);
                m_pend_v = 0;
            end
            if (r) begin
                if (m_eval_due == cyc) begin
                    m_pend   = b;
                    m_pend_v = 1;
                end else begin
                    model_byte(b, cyc, prompt);
                end
            end
            if (prompt) begin
                res  = 1;
                code = 3'd3;
                clr  = 1;
            end
            if (!res && expire) begin
                res  = 1;
                code = 3'd6;
            end
            if (expire) clr = 1;
            if (ws) begin
                m_busy     = 1;
                m_deadline = cyc + c_T;
            end else if (clr) begin
                m_busy = 0;
            end
            if (res) m_code = code;
            m_exp_valid = res;
        end
        #1;
        check("resp_valid", resp_valid, m_exp_valid);
        check("resp_code", resp_code, m_code);
        check("busy", busy, m_busy);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, byte'($urandom), 0, 0);
    endtask

    task automatic send(input byte b, input int gap, input bit ws = 0);
        tick(1, b, ws, 0);
        idle(gap);
    endtask

    // gap 0 after a line-ending LF lands the next byte in the EVAL cycle.
    task automatic send_str(input string s, input int gap, input bit tight_lf = 0);
        bit tight = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (tight) begin
                send(s[i], 1);
                tight = 0;
            end else if (tight_lf && s[i] == 8'h0A) begin
                send(s[i], 0);
                tight = 1;
            end else begin
                send(s[i], gap);
            end
        end
    endtask

    string lines [12] = '{"OK", "ERROR", "+CMGS: 3", "+CMTI: \"SM\",1", "RING",
                          "AT+CMGS=\"1\"", "ERRORS", "OKAY", "O", "+CMG", "", "RINGING"};
    string chars = "OKERGIN+CMTS:> ";

    initial begin
        tick(0, 8'h00, 0, 1);
        tick(0, 8'h00, 0, 1);
        idle(2);

        send(8'h00, 1, 1);
        send_str("AT\r\r\nOK\r\n", 2);
        idle(4);

        send(8'h00, 1, 1);
        send_str("\r\n> ", 2);
        idle(4);
        send_str("\r\n", 2);

        send(8'h00, 1, 1);
        send_str("+CMGS: 17\r\nOK\r\n", 1);
        send_str("ERRORXXXXXXX\r\nERROR\r\n", 1);
        idle(3);

        send(8'h00, 0, 1);
        idle(c_T + 5);
        send(8'h00, 49, 1);
        send(8'h00, 0, 1);
        idle(c_T + 5);

        send_str("OK", 1);
        tick(0, 8'h00, 0, 1);
        send_str("\r\n", 2);
        idle(3);

        send(8'h00, 1, 1);
        send_str("RING\r\n", 2);
        idle(c_T);

        send_str("OK\r\n>X\r\nEND\r\n", 1, 1);
        idle(3);

        send(8'h00, 1, 1);
        send_str("Q\r", 1);
        tick(1, 8'h0A, 0, 0);
        tick(0, 8'h00, 1, 0);
        idle(3);

        // Line result lands on the expiry edge.
        send(8'h00, c_T - 4, 1);
        send("Z", 1);
        send(8'h0A, 4);
        idle(3);

        for (int k = 0; k < 300; k++) begin
            string s;
            int    sel = $urandom_range(0, 14);
            if (sel < 12) s = lines[sel];
            else if (sel == 12) s = ">";
            else begin
                s = "";
                for (int j = 0; j < $urandom_range(1, 12); j++) begin
                    int p = $urandom_range(0, chars.len() - 1);
                    s = {s, chars.substr(p, p)};
                end
            end
            if (sel != 12) s = {s, "\r\n"};
            if ($urandom_range(0, 5) == 0) send(8'h00, $urandom_range(0, 2), 1);
            if ($urandom_range(0, 7) == 0) begin
                tick(1, s[0], 1, 0);
                idle(1);
                s = s.substr(1, s.len() - 1);
            end
            send_str(s, $urandom_range(1, 3), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(20, c_T + 10));
            if ($urandom_range(0, 40) == 0) tick(0, 8'h00, 0, 1);
        end
        idle(c_T + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gsm_resp_parser.md
Name: gsm_resp_parser

Overview:
- Receive-side partner of the GSM short-message transmit path.
- Consumes bytes from a UART receiver attached to the GSM modem's TX line.
- Classifies modem replies ("OK", "ERROR", ">" prompt, "+CMGS:" and others) and reports one result code per reply.
- Provides a response timeout so the message sequencer can advance or retry on a decided event instead of fixed delays.

Parameters:
- MAX_LEN, 8: number of line characters stored for matching; extra characters are counted but not stored.
- TIMEOUT_CYC, 24'd12_000_000: clk cycles from wait_start to timeout (about 0.24 s at 50 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx_byte  input  8  received byte from the modem UART receiver.
- rx_int  input  1  one-cycle strobe; rx_byte is valid in that cycle.
- wait_start  input  1  one-cycle pulse; arms or re-arms the timeout counter.
- resp_valid  output  1  one-cycle pulse when a result is available.
- resp_code  output  3  result: 0 none, 1 OK, 2 ERROR, 3 PROMPT, 4 CMGS, 5 OTHER, 6 TIMEOUT, 7 RING.
- busy  output  1  high while the timeout counter is armed.

Behaviour:
- Synchronous reset (rst=1 at a clk edge) clears:
  - resp_valid=0, resp_code=0, busy=0;
  - line buffer and length counter; state is IDLE.
- Reset mid-line discards the partial line.
- State machine:
  - IDLE: no characters held. A byte other than CR, LF or '>' moves to COLLECT and is stored at index 0. CR and LF are ignored.
  - '>' in IDLE is the send prompt: resp_valid pulses with code 3 on the cycle after that rx_int. The state stays IDLE. No LF is required.
  - COLLECT: CR is discarded. Any other non-LF byte is stored while length < MAX_LEN. The length counter increments and saturates at 63.
  - LF moves to EVAL.
  - EVAL (one cycle) classifies the line, then returns to IDLE with the buffer cleared:
    - length==2 and "OK" -> code 1;
    - length==5 and "ERROR" -> code 2;
    - length>=6 and prefix "+CMGS:" -> code 4;
    - otherwise -> code 5.
- Latency: resp_valid is asserted in the cycle after EVAL, i.e. 2 cycles after the LF strobe. resp_code holds its value until the next resp_valid.
- Empty lines (CR LF only) never produce resp_valid.
- Timeout counter:
  - wait_start loads the counter with TIMEOUT_CYC and sets busy=1.
  - busy clears on any resp_valid or on expiry.
  - Expiry gives resp_valid with code 6; busy=0 in the same cycle.
  - If busy=0, nothing is counted.
- Simultaneous events:
  - wait_start together with rx_int: the byte is processed normally and the counter reloads.
  - wait_start in the same cycle as a result pulse: the result is reported and busy stays 1, newly armed.
  - Counter expiry in the same cycle as a line result: the line result wins, the timeout is dropped and busy clears.
- rx_int arriving during EVAL: the byte is held in a one-entry skid register and processed on the next cycle. No byte is lost for rx_int spacing ≥1 cycle.

Optional Feature:
- Macro GSM_RESP_RING_EN.
- Defined: the lines "RING" (length 4) and "+CMTI:" (prefix) are classified as code 7. They are unsolicited, so they do not clear busy or stop the timer.
- Undefined: those lines give code 5 and are treated like any other line, i.e. they clear busy.

Test Plan:
- Bytes "AT\r\r\nOK\r\n" after wait_start -> pulse code 5 (echo line "AT"), then code 1, 2 cycles after the final LF; busy=0.
- "\r\n> " with busy=1 -> code 3 one cycle after the '>' strobe; no further pulse from the space; busy=0.
- "+CMGS: 17\r\nOK\r\n" -> code 4, then code 1. A 12-character line "ERRORXXXXXXX\r\n" -> code 5 (length ≠5).
- wait_start, no input for TIMEOUT_CYC cycles (bench sets parameter 100) -> code 6 at cycle 100; second wait_start at cycle 50 -> expiry moves to cycle 150.
- rst asserted after "OK" without LF, then "\r\n" -> no resp_valid; resp_code=0; busy=0.
- With GSM_RESP_RING_EN: "RING\r\n" while busy -> code 7, busy stays 1, timeout still fires. Without the macro -> code 5, busy clears.
